fm_sweep_ctrl: RTL and testbench

FM_SWEEP_CTRL -- requirements
Module: fm_sweep_ctrl

---
 rtl/fm_sweep_pkg.sv | 21 ++
 rtl/fm_dwell_timer.sv | 24 ++
 rtl/fm_sweep_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fm_sweep_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fm_sweep_pkg.sv
// Shared types and default widths for the FM sweep controller.
// The RETURN state exists only when FM_SWEEP_TRI_EN is defined.
package fm_sweep_pkg;

  localparam int FM_FW_DEF = 32;
  localparam int FM_DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1
`ifdef FM_SWEEP_TRI_EN
    ,ST_RETURN = 2'd2
`endif
  } sweep_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } sweep_dir_t;

endpackage

// File: rtl/fm_dwell_timer.sv
// Loadable dwell down-counter. tc is high while the count is zero, so a
// load value of N gives exactly N+1 cycles per held control word.
module fm_dwell_timer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  output logic          tc
);

  logic [DW-1:0] count;

  // Reload on each new control word, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - DW'(1);
  end

  assign tc = (count == '0);

endmodule

// File: rtl/fm_sweep_ctrl.sv
// FM sweep controller: steps an NCO control word from f_start to f_stop,
// holding each value dwell+1 cycles, with clamping at the stop value.
// Optional up-then-down (triangle) sweep is enabled by FM_SWEEP_TRI_EN.
module fm_sweep_ctrl
  import fm_sweep_pkg::*;
#(
  parameter int FW = FM_FW_DEF,
  parameter int DW = FM_DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  input  logic          repeat_en,
`ifdef FM_SWEEP_TRI_EN
  input  logic          tri_en,
`endif
  output logic [FW-1:0] ctrl,
  output logic          busy,
  output logic          done
);

  sweep_state_t  state;
  sweep_dir_t    dir_q;
  logic [FW-1:0] start_q, stop_q, step_q;
  logic [DW-1:0] dwell_q;
  logic          rep_q;
`ifdef FM_SWEEP_TRI_EN
  logic          tri_q;
  logic [FW-1:0] bwd;
`endif
  logic [FW-1:0] fwd;
  logic          tc, tmr_load, accept;
  logic [DW-1:0] tmr_val;

  // Next word toward target, computed one bit wider so overflow or
  // underflow clamps to the target instead of wrapping. Zero step jumps.
  function automatic logic [FW-1:0] step_toward(
    input logic [FW-1:0] cur,
    input logic [FW-1:0] step,
    input logic [FW-1:0] target,
    input logic          up
  );
    logic [FW:0]   nxt;
    logic [FW-1:0] res;
    if (up) nxt = {1'b0, cur} + {1'b0, step};
    else    nxt = {1'b0, cur} - {1'b0, step};
    res = nxt[FW-1:0];
    if (step == '0)                                   res = target;
    else if (up && (nxt >= {1'b0, target}))           res = target;
    else if (!up && (nxt[FW] || nxt[FW-1:0] <= target)) res = target;
    return res;
  endfunction

  // Candidate next words for the outbound leg and (optionally) the return leg.
  always_comb begin
    fwd = step_toward(ctrl, step_q, stop_q, dir_q == DIR_UP);
`ifdef FM_SWEEP_TRI_EN
    bwd = step_toward(ctrl, step_q, start_q, dir_q == DIR_DOWN);
`endif
  end

  // Timer reloads on sweep start and on every dwell expiry while active.
  always_comb begin
    accept   = (state == ST_IDLE) && start && !abort;
    tmr_load = accept || ((state != ST_IDLE) && tc && !abort);
    tmr_val  = (state == ST_IDLE) ? dwell : dwell_q;
  end

  fm_dwell_timer #(.DW(DW)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  // Sweep FSM with registered ctrl/busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ctrl    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dir_q   <= DIR_UP;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      rep_q   <= 1'b0;
`ifdef FM_SWEEP_TRI_EN
      tri_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            start_q <= f_start;
            stop_q  <= f_stop;
            step_q  <= f_step;
            dwell_q <= dwell;
            rep_q   <= repeat_en;
            dir_q   <= (f_stop >= f_start) ? DIR_UP : DIR_DOWN;
`ifdef FM_SWEEP_TRI_EN
            tri_q   <= tri_en;
`endif
            ctrl    <= f_start;
            busy    <= 1'b1;
            state   <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (tc) begin
            if (ctrl == stop_q) begin
`ifdef FM_SWEEP_TRI_EN
              if (tri_q) begin
                state <= ST_RETURN;
                ctrl  <= bwd;
              end else
`endif
              if (rep_q) begin
                ctrl <= start_q;
                done <= 1'b1;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              ctrl <= fwd;
            end
          end
        end
`ifdef FM_SWEEP_TRI_EN
        ST_RETURN: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (tc) begin
            if (ctrl == start_q) begin
              done <= 1'b1;
              if (rep_q) begin
                // ctrl equals start_q here, so fwd is the first outbound step.
                state <= ST_SWEEP;
                ctrl  <= fwd;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              ctrl <= bwd;
            end
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fm_sweep_ctrl.sv
// Directed bench for fm_sweep_ctrl with hand-computed expected words.
module tb_fm_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] f_start = '0, f_stop = '0, f_step = '0;
  logic [15:0] dwell = '0;
  logic        repeat_en = 1'b0;
`ifdef FM_SWEEP_TRI_EN
  logic        tri_en = 1'b0;
`endif
  logic [31:0] ctrl;
  logic        busy, done;

  int nvec = 0;
  int nerr = 0;

  fm_sweep_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .repeat_en (repeat_en),
`ifdef FM_SWEEP_TRI_EN
    .tri_en    (tri_en),
`endif
    .ctrl      (ctrl),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                    input logic [15:0] dw, input logic rep);
    f_start = fs; f_stop = fe; f_step = st; dwell = dw; repeat_en = rep;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic obs3(input string tag, input logic [31:0] c, input logic b, input logic d);
    chk({tag, "_ctrl"}, 64'(ctrl), 64'(c));
    chk({tag, "_busy"}, 64'(busy), 64'(b));
    chk({tag, "_done"}, 64'(done), 64'(d));
  endtask

  initial begin
    logic [31:0] exp_a [8];
    logic [31:0] exp_c [6];
    exp_a = '{100, 100, 110, 110, 120, 120, 130, 130};
    exp_c = '{50, 35, 20, 50, 35, 20};

    // Reset state
    #2;
    obs3("reset", 0, 0, 0);
    tick();
    #2 rst_n = 1'b1;

    // Basic up sweep, start on first edge after release; inputs changed after latch
    go(100, 130, 10, 1, 0);
    f_start = 7; f_stop = 999; f_step = 1; dwell = 5;
    for (int i = 0; i < 8; i++) begin
      obs3($sformatf("up_%0d", i), exp_a[i], 1, 0);
      tick();
    end
    obs3("up_end", 130, 0, 1);
    tick();
    obs3("up_after", 130, 0, 0);

    // Clamp at top of range without wrap
    go(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 0);
    obs3("clamp_0", 32'hFFFF_FFF0, 1, 0);
    tick();
    obs3("clamp_1", 32'hFFFF_FFFF, 1, 0);
    tick();
    obs3("clamp_end", 32'hFFFF_FFFF, 0, 1);

    // Down sweep with repeat; done pulses on each return to 50
    go(50, 20, 15, 0, 1);
    for (int i = 0; i < 6; i++) begin
      obs3($sformatf("rep_%0d", i), exp_c[i], 1, (i == 3) ? 1'b1 : 1'b0);
      tick();
    end
    obs3("rep_wrap2", 50, 1, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    obs3("rep_abort", 50, 0, 0);

    // Abort at the second step
    go(100, 130, 10, 1, 0);
    tick(); tick();
    obs3("ab_pre", 110, 1, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    obs3("ab_0", 110, 0, 0);
    tick();
    obs3("ab_1", 110, 0, 0);

    // Start and abort together in IDLE are ignored
    f_start = 5; f_stop = 9; f_step = 1; dwell = 0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    obs3("st_ab", 110, 0, 0);

    // Start while busy ignored
    go(200, 260, 30, 2, 0);
    f_start = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    obs3("busy_start", 200, 1, 0);
    tick(); tick();
    obs3("busy_step", 230, 1, 0);

    // Reset mid-sweep is immediate, then a fresh start sweeps normally
    #3 rst_n = 1'b0;
    #1;
    obs3("rst_mid", 0, 0, 0);
    #2 rst_n = 1'b1;
    tick();
    obs3("rst_idle", 0, 0, 0);
    go(100, 130, 10, 0, 0);
    obs3("rst_re0", 100, 1, 0);
    tick();
    obs3("rst_re1", 110, 1, 0);
    tick(); tick(); tick();
    obs3("rst_reend", 130, 0, 1);

    // Zero step jumps straight to stop after one dwell
    go(10, 40, 0, 0, 0);
    obs3("z_0", 10, 1, 0);
    tick();
    obs3("z_1", 40, 1, 0);
    tick();
    obs3("z_end", 40, 0, 1);

    // start == stop, dwell 0, repeat: done on consecutive cycles
    go(7, 7, 3, 0, 1);
    obs3("eq_0", 7, 1, 0);
    tick();
    obs3("eq_1", 7, 1, 1);
    tick();
    obs3("eq_2", 7, 1, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    obs3("eq_abort", 7, 0, 0);

`ifdef FM_SWEEP_TRI_EN
    // Triangle sweep 100 -> 120 -> 100
    tri_en = 1'b1;
    go(100, 120, 10, 0, 0);
    tri_en = 1'b0;
    obs3("tri_0", 100, 1, 0);
    tick(); obs3("tri_1", 110, 1, 0);
    tick(); obs3("tri_2", 120, 1, 0);
    tick(); obs3("tri_3", 110, 1, 0);
    tick(); obs3("tri_4", 100, 1, 0);
    tick(); obs3("tri_end", 100, 0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
